hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 ID_RS1, ID_RS2  input  5 each  source registers of the instruction in ID.
REQ-004 ID_USES_RS1, ID_USES_RS2  input  1 each  source operand actually read by the ID instruction.
REQ-005 EX_RD  input  5  destination register of the instruction in EX.
REQ-006 EX_MEM_READ  input  1  EX instruction is a load.
REQ-007 EX_BRANCH_TAKEN  input  1  EX resolved a taken branch/jump (redirect).
REQ-008 EX_IS_DIV  input  1  EX holds a valid DIV/DIVU/REM/REMU.
REQ-009 DIV_DONE  input  1  divider result valid (single-cycle pulse).
REQ-010 DIV_START  output  1  one-cycle launch pulse to the divider.
REQ-011 PC_STALL, IF_ID_STALL, ID_EX_STALL  output  1 each  hold the named register.
REQ-012 IF_ID_FLUSH, ID_EX_FLUSH  output  1 each  load NOP/zero into the named register.
REQ-013 EX_MEM_BUBBLE  output  1  inject NOP into EX/MEM.
REQ-014 DIV_ERROR  output  1  sticky divider-timeout flag.
REQ-015 STALL_CYCLES, FLUSH_EVENTS  output  16 each  saturating performance counters.

Function
REQ-016 FSM states: IDLE, DIV_WAIT; flush/stall outputs are combinational from state and inputs.
REQ-017 Load-use hazard = EX_MEM_READ and EX_RD != 0 and ((ID_USES_RS1 and ID_RS1 == EX_RD) or (ID_USES_RS2 and ID_RS2 == EX_RD)).
REQ-018 Load-use in IDLE, no branch: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1 for exactly that cycle.
REQ-019 EX_BRANCH_TAKEN in IDLE: IF_ID_FLUSH=1, ID_EX_FLUSH=1, no stalls; overrides load-use and EX_IS_DIV.
REQ-020 IDLE with EX_IS_DIV and no branch: DIV_START=1, PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_BUBBLE all 1; next state DIV_WAIT.
REQ-021 DIV_WAIT with DIV_DONE=0: same four stall/bubble outputs 1, DIV_START=0; load-use and branch inputs ignored.
REQ-022 DIV_WAIT with DIV_DONE=1: all stall/bubble/flush outputs 0 that cycle (pipeline advances); next state IDLE.
REQ-023 Back-to-back divides: new DIV_START no earlier than the cycle after the DIV_DONE cycle.
REQ-024 Timeout counter (6 bits) cleared on DIV_WAIT entry, increments per DIV_WAIT cycle; at 63 without DIV_DONE: DIV_ERROR set, state to IDLE, stalls released.
REQ-025 DIV_DONE in IDLE is ignored.
REQ-026 STALL_CYCLES increments every cycle PC_STALL=1; FLUSH_EVENTS increments every cycle IF_ID_FLUSH=1; both saturate at 16'hFFFF.

Reset
REQ-027 RESET asserted: state IDLE, timeout counter 0, DIV_ERROR 0, both perf counters 0, regardless of CLK.
REQ-028 RESET mid-DIV_WAIT abandons the divide; no DIV_START until EX_IS_DIV is seen again after release.
REQ-029 During RESET, combinational outputs reflect IDLE with current inputs; stall counters do not advance.

Structure
REQ-030 State encodings (IDLE=1'b0, DIV_WAIT=1'b1) and DIV_TIMEOUT=63 live in the shared pipeline defines header.
REQ-031 One sub-module, sat_counter16 (enable, async clear, saturating 16-bit), instantiated twice for the perf counters.
REQ-032 No other hierarchy; target 150-250 lines RTL.

Verification
REQ-033 EX_MEM_READ=1, EX_RD=5, ID_RS1=5, ID_USES_RS1=1 -> one cycle PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1; STALL_CYCLES=1.
REQ-034 Same as REQ-033 but EX_RD=0, or ID_USES_RS1=0 -> no stall, no flush.
REQ-035 Load-use plus EX_BRANCH_TAKEN same cycle -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0; FLUSH_EVENTS=1.
REQ-036 EX_IS_DIV=1, DIV_DONE after 10 cycles -> DIV_START pulse in cycle 0, stalls high cycles 0-9, low in DONE cycle, STALL_CYCLES=10.
REQ-037 EX_IS_DIV, DIV_DONE never -> DIV_ERROR=1 after timeout, state IDLE; RESET mid-wait -> all counters 0, DIV_START absent until EX_IS_DIV re-seen.
REQ-038 Force 70000 stall cycles -> STALL_CYCLES holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encodings,
// divider timeout limit, performance counter width and the control bundle.
package hazard_control_pkg;

   // Controller states; the encodings are fixed so other pipeline blocks can
   // decode them.
   typedef enum logic {
      IDLE     = 1'b0,
      DIV_WAIT = 1'b1
   } hc_state_e;

   // Divider watchdog: number of DIV_WAIT cycles tolerated before giving up.
   localparam int              TMO_W       = 6;
   localparam logic [TMO_W-1:0] DIV_TIMEOUT = 6'd63;

   // Performance counter geometry.
   localparam int              CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   // Every pipeline control line driven by the controller, kept together so
   // the decode logic can default the whole bundle in one assignment.
   typedef struct packed {
      logic div_start;
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_bubble;
   } hc_ctrl_t;

   // A load in EX feeds a register that the ID instruction really reads.
   // Register x0 is hard-wired to zero, so it never creates a dependency.
   function automatic logic load_use_hazard(
      input logic       mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] rs1,
      input logic       uses_rs1,
      input logic [4:0] rs2,
      input logic       uses_rs2
   );
      return mem_read && (ex_rd != 5'd0) &&
             ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/hazard_control_sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
// Used for the stall and flush performance counters.
module sat_counter16
   import hazard_control_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   output logic [CNT_W-1:0] COUNT
);

   // Count enabled cycles, holding at the top value once reached.
   always_ff @(posedge CLK or posedge RESET) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples
      // pre-edge values; blocking here would create order-dependent races.
      if (RESET) begin
         COUNT <= '0;
      end else if (EN && (COUNT != CNT_MAX)) begin
         COUNT <= COUNT + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and a
// multi-cycle divider handshake with a watchdog, plus stall/flush counters.
// All pipeline control lines are combinational from state and inputs.
module hazard_control
   import hazard_control_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_USES_RS1,
   input  logic             ID_USES_RS2,
   input  logic [4:0]       EX_RD,
   input  logic             EX_MEM_READ,
   input  logic             EX_BRANCH_TAKEN,
   input  logic             EX_IS_DIV,
   input  logic             DIV_DONE,
   output logic             DIV_START,
   output logic             PC_STALL,
   output logic             IF_ID_STALL,
   output logic             ID_EX_STALL,
   output logic             IF_ID_FLUSH,
   output logic             ID_EX_FLUSH,
   output logic             EX_MEM_BUBBLE,
   output logic             DIV_ERROR,
   output logic [CNT_W-1:0] STALL_CYCLES,
   output logic [CNT_W-1:0] FLUSH_EVENTS
);

   hc_state_e        state_q;
   hc_state_e        state_d;
   logic [TMO_W-1:0] tmo_q;
   logic             error_set;
   logic             load_use;
   hc_ctrl_t         ctrl;

   assign load_use = load_use_hazard(EX_MEM_READ, EX_RD, ID_RS1, ID_USES_RS1,
                                     ID_RS2, ID_USES_RS2);

   // State register; reset abandons any divide in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Watchdog: zero while idle, so it starts from 0 on every DIV_WAIT entry,
   // then counts each cycle spent waiting on the divider.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tmo_q <= '0;
      end else if (state_q == IDLE) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   // Sticky divider-timeout flag; only reset clears it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         DIV_ERROR <= 1'b0;
      end else if (error_set) begin
         DIV_ERROR <= 1'b1;
      end
   end

   // Next-state and control decode. Branch redirect has top priority in
   // IDLE; while waiting on the divider, only DIV_DONE and the watchdog matter.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      ctrl      = '0;
      state_d   = state_q;
      error_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (EX_BRANCH_TAKEN) begin
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end else if (EX_IS_DIV) begin
               ctrl.div_start     = 1'b1;
               ctrl.pc_stall      = 1'b1;
               ctrl.if_id_stall   = 1'b1;
               ctrl.id_ex_stall   = 1'b1;
               ctrl.ex_mem_bubble = 1'b1;
               state_d            = DIV_WAIT;
            end else if (load_use) begin
               ctrl.pc_stall    = 1'b1;
               ctrl.if_id_stall = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end
         end
         DIV_WAIT: begin
            if (DIV_DONE) begin
               // Result is ready: release everything so the divide retires.
               state_d = IDLE;
            end else if (tmo_q == DIV_TIMEOUT) begin
               // Divider never answered: flag it and let the pipeline go.
               state_d   = IDLE;
               error_set = 1'b1;
            end else begin
               ctrl.pc_stall      = 1'b1;
               ctrl.if_id_stall   = 1'b1;
               ctrl.id_ex_stall   = 1'b1;
               ctrl.ex_mem_bubble = 1'b1;
            end
         end
      endcase
   end

   assign DIV_START     = ctrl.div_start;
   assign PC_STALL      = ctrl.pc_stall;
   assign IF_ID_STALL   = ctrl.if_id_stall;
   assign ID_EX_STALL   = ctrl.id_ex_stall;
   assign IF_ID_FLUSH   = ctrl.if_id_flush;
   assign ID_EX_FLUSH   = ctrl.id_ex_flush;
   assign EX_MEM_BUBBLE = ctrl.ex_mem_bubble;

   // Cycles in which the front end was held.
   sat_counter16 u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (ctrl.pc_stall),
      .COUNT (STALL_CYCLES)
   );

   // Cycles in which the fetched instruction was squashed.
   sat_counter16 u_flush_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (ctrl.if_id_flush),
      .COUNT (FLUSH_EVENTS)
   );

endmodule

// File: tb/tb_hazard_control.sv
// Directed, table-driven bench for hazard_control with hand-written
// sequences for the divider handshake, watchdog, reset and saturation.
module tb_hazard_control;

   logic        CLK;
   logic        RESET;
   logic [4:0]  ID_RS1, ID_RS2, EX_RD;
   logic        ID_USES_RS1, ID_USES_RS2;
   logic        EX_MEM_READ, EX_BRANCH_TAKEN, EX_IS_DIV, DIV_DONE;
   logic        DIV_START, PC_STALL, IF_ID_STALL, ID_EX_STALL;
   logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, DIV_ERROR;
   logic [15:0] STALL_CYCLES, FLUSH_EVENTS;

   // Observed control bundle: {start, pc_stall, if_id_stall, id_ex_stall,
   // if_id_flush, id_ex_flush, ex_mem_bubble}
   logic [6:0]  obs;
   assign obs = {DIV_START, PC_STALL, IF_ID_STALL, ID_EX_STALL,
                 IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE};

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b0110010;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_DS   = 7'b1111001;
   localparam logic [6:0] C_DW   = 7'b0111001;

   int n_cmp = 0;
   int n_err = 0;

   hazard_control dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .ID_RS1          (ID_RS1),
      .ID_RS2          (ID_RS2),
      .ID_USES_RS1     (ID_USES_RS1),
      .ID_USES_RS2     (ID_USES_RS2),
      .EX_RD           (EX_RD),
      .EX_MEM_READ     (EX_MEM_READ),
      .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
      .EX_IS_DIV       (EX_IS_DIV),
      .DIV_DONE        (DIV_DONE),
      .DIV_START       (DIV_START),
      .PC_STALL        (PC_STALL),
      .IF_ID_STALL     (IF_ID_STALL),
      .ID_EX_STALL     (ID_EX_STALL),
      .IF_ID_FLUSH     (IF_ID_FLUSH),
      .ID_EX_FLUSH     (ID_EX_FLUSH),
      .EX_MEM_BUBBLE   (EX_MEM_BUBBLE),
      .DIV_ERROR       (DIV_ERROR),
      .STALL_CYCLES    (STALL_CYCLES),
      .FLUSH_EVENTS    (FLUSH_EVENTS)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       dv;
      logic [6:0] exp;
   } vec_t;

   function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2,
                               logic u1, logic u2, logic [4:0] rd, logic mr,
                               logic br, logic dv, logic [6:0] exp);
      vec_t v;
      v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.rd = rd; v.mr = mr; v.br = br; v.dv = dv; v.exp = exp;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      ID_RS1 = '0; ID_RS2 = '0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
      EX_RD = '0; EX_MEM_READ = 0; EX_BRANCH_TAKEN = 0;
      EX_IS_DIV = 0; DIV_DONE = 0;
   endtask

   task automatic set_lu();
      ID_RS1 = 5'd5; ID_USES_RS1 = 1; EX_RD = 5'd5; EX_MEM_READ = 1;
   endtask

   // Advance one cycle; inputs then change 2 time units after the edge.
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RESET = 1;
      clear_in();
      #1;
      RESET = 0;
      #1;
   endtask

   vec_t vecs[11];
   int   exp_stall;
   int   exp_flush;

   initial begin
      vecs[0]  = mk("lu_rs1",        5'd5,  5'd0,  1, 0, 5'd5,  1, 0, 0, C_LU);
      vecs[1]  = mk("lu_rd_zero",    5'd0,  5'd0,  1, 0, 5'd0,  1, 0, 0, C_NONE);
      vecs[2]  = mk("lu_rs1_unused", 5'd5,  5'd0,  0, 0, 5'd5,  1, 0, 0, C_NONE);
      vecs[3]  = mk("lu_rs2",        5'd0,  5'd7,  0, 1, 5'd7,  1, 0, 0, C_LU);
      vecs[4]  = mk("lu_both_unused",5'd7,  5'd7,  0, 0, 5'd7,  1, 0, 0, C_NONE);
      vecs[5]  = mk("no_load",       5'd5,  5'd5,  1, 1, 5'd5,  0, 0, 0, C_NONE);
      vecs[6]  = mk("lu_plus_branch",5'd5,  5'd0,  1, 0, 5'd5,  1, 1, 0, C_BR);
      vecs[7]  = mk("branch_only",   5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, C_BR);
      vecs[8]  = mk("lu_reg31",      5'd31, 5'd31, 1, 1, 5'd31, 1, 0, 0, C_LU);
      vecs[9]  = mk("lu_no_match",   5'd3,  5'd4,  1, 1, 5'd5,  1, 0, 0, C_NONE);
      vecs[10] = mk("branch_div",    5'd0,  5'd0,  0, 0, 5'd0,  0, 1, 1, C_BR);

      // Reset state
      RESET = 1;
      clear_in();
      #3;
      check("rst_ctrl", obs, C_NONE);
      check("rst_stall_cnt", STALL_CYCLES, 0);
      check("rst_flush_cnt", FLUSH_EVENTS, 0);
      check("rst_div_error", DIV_ERROR, 0);
      step();
      RESET = 0;

      // Single load-use stall
      set_lu();
      #1;
      check("lu_ctrl", obs, C_LU);
      step();
      clear_in();
      #1;
      check("lu_released", obs, C_NONE);
      check("lu_stall_cnt", STALL_CYCLES, 1);

      // Load-use with redirect: branch wins
      set_lu();
      EX_BRANCH_TAKEN = 1;
      #1;
      check("lu_br_ctrl", obs, C_BR);
      step();
      clear_in();
      #1;
      check("lu_br_flush_cnt", FLUSH_EVENTS, 1);
      check("lu_br_stall_cnt", STALL_CYCLES, 1);

      // Table of single-cycle IDLE decodes
      exp_stall = 1;
      exp_flush = 1;
      for (int i = 0; i < 11; i++) begin
         ID_RS1 = vecs[i].rs1; ID_RS2 = vecs[i].rs2;
         ID_USES_RS1 = vecs[i].u1; ID_USES_RS2 = vecs[i].u2;
         EX_RD = vecs[i].rd; EX_MEM_READ = vecs[i].mr;
         EX_BRANCH_TAKEN = vecs[i].br; EX_IS_DIV = vecs[i].dv;
         #1;
         check(vecs[i].name, obs, vecs[i].exp);
         exp_stall += int'(vecs[i].exp[5]);
         exp_flush += int'(vecs[i].exp[2]);
         step();
      end
      clear_in();
      #1;
      check("tbl_after_idle", obs, C_NONE);
      check("tbl_stall_cnt", STALL_CYCLES, exp_stall);
      check("tbl_flush_cnt", FLUSH_EVENTS, exp_flush);

      // Divide finishing after 10 cycles; hazards ignored while waiting
      do_reset();
      EX_IS_DIV = 1;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) begin
            set_lu();
            EX_BRANCH_TAKEN = 1;
         end
         #1;
         check($sformatf("div_cyc%0d", c), obs, (c == 0) ? C_DS : C_DW);
         step();
         if (c == 5) begin
            clear_in();
            EX_IS_DIV = 1;
         end
      end
      DIV_DONE = 1;
      #1;
      check("div_done_cycle", obs, C_NONE);
      step();
      DIV_DONE = 0;
      #1;
      check("div_b2b_start", obs, C_DS);
      clear_in();
      #1;
      check("div_stall_cnt", STALL_CYCLES, 10);

      // DIV_DONE while idle has no effect
      DIV_DONE = 1;
      #1;
      check("done_in_idle", obs, C_NONE);
      step();
      DIV_DONE = 0;
      EX_IS_DIV = 1;
      #1;
      check("idle_after_stray_done", obs, C_DS);
      clear_in();

      // Divider never answers: watchdog fires on the 64th waiting cycle
      do_reset();
      EX_IS_DIV = 1;
      for (int c = 0; c <= 64; c++) begin
         #1;
         check($sformatf("tmo_cyc%0d", c), obs,
               (c == 0) ? C_DS : ((c == 64) ? C_NONE : C_DW));
         if (c == 64) check("tmo_err_before", DIV_ERROR, 0);
         step();
      end
      clear_in();
      #1;
      check("tmo_div_error", DIV_ERROR, 1);
      check("tmo_stall_cnt", STALL_CYCLES, 64);
      check("tmo_idle_ctrl", obs, C_NONE);
      EX_IS_DIV = 1;
      #1;
      check("tmo_back_idle", obs, C_DS);
      clear_in();
      repeat (3) step();
      check("tmo_error_sticky", DIV_ERROR, 1);

      // Reset in the middle of a divide
      do_reset();
      EX_IS_DIV = 1;
      repeat (3) step();
      check("mid_stall_cnt", STALL_CYCLES, 3);
      check("mid_waiting", obs, C_DW);
      RESET = 1;
      clear_in();
      #1;
      check("mid_rst_cnt", STALL_CYCLES, 0);
      check("mid_rst_ctrl", obs, C_NONE);
      set_lu();
      #1;
      check("rst_comb_lu", obs, C_LU);
      step();
      check("rst_cnt_frozen", STALL_CYCLES, 0);
      clear_in();
      RESET = 0;
      #1;
      check("post_rst_no_start", obs, C_NONE);
      step();
      check("post_rst_idle", obs, C_NONE);
      EX_IS_DIV = 1;
      #1;
      check("post_rst_restart", obs, C_DS);
      clear_in();

      // Saturation of the stall counter
      do_reset();
      set_lu();
      repeat (65534) step();
      check("sat_near_max", STALL_CYCLES, 16'hFFFE);
      repeat (70000 - 65534) step();
      check("sat_hold_max", STALL_CYCLES, 16'hFFFF);
      clear_in();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
